i2s_rx: RTL and testbench

- I2S receiver for the audio path. It deserialises a bclk/lrck/din stream, as produced by the board's I2S DAC feeder, into 16-bit left/right samples in the clk32 domain.
- Uses: loopback verification of the audio output and capture from an external I2S ADC/codec on a PMOD.
- Oversampled design: bclk, lrck and din are asynchronous inputs, sampled by clk32; no second clock domain.

---
 rtl/i2s_rx.sv | 150 +++++++++++++++
 tb/tb_i2s_rx.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/i2s_rx.sv
// I2S receiver: oversamples bclk/lrck/din in the clk32 domain and deserialises
// 16-bit left/right samples, with framing-error, timeout and lock tracking.
module i2s_rx #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = 255,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic        clk32,
  input  logic        reset_n,
  input  logic        i2s_bclk,
  input  logic        i2s_lrck,
  input  logic        i2s_din,
  output logic [15:0] left,
  output logic [15:0] right,
  output logic        valid,
  output logic        locked,
  output logic        err
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam int unsigned GW = $clog2(LOCK_FRAMES + 1);

  logic [SYNC_STAGES-1:0] bclk_sync, lrck_sync, din_sync;
  logic                   bclk_d, sample_q, lrck_q, din_q;
  logic                   fall_c;

  logic [15:0]   shreg, shreg_n, pending_left, pending_n, left_n, right_n;
  logic [4:0]    bitcnt, bitcnt_n;
  logic          lrck_prev, lrck_prev_n, primed, primed_n, have_left, have_left_n;
  logic [GW-1:0] gcnt, gcnt_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic          locked_n, valid_n, err_n;

  assign fall_c = bclk_d & ~bclk_sync[SYNC_STAGES-1];

  // Synchronisers plus a registered sample strobe with its lrck/din bits.
  always_ff @(posedge clk32 or negedge reset_n) begin
    if (!reset_n) begin
      bclk_sync <= '0;
      lrck_sync <= '0;
      din_sync  <= '0;
      bclk_d    <= 1'b0;
      sample_q  <= 1'b0;
      lrck_q    <= 1'b0;
      din_q     <= 1'b0;
    end else begin
      bclk_sync <= {bclk_sync[SYNC_STAGES-2:0], i2s_bclk};
      lrck_sync <= {lrck_sync[SYNC_STAGES-2:0], i2s_lrck};
      din_sync  <= {din_sync[SYNC_STAGES-2:0], i2s_din};
      bclk_d    <= bclk_sync[SYNC_STAGES-1];
      sample_q  <= fall_c;
      lrck_q    <= lrck_sync[SYNC_STAGES-1];
      din_q     <= din_sync[SYNC_STAGES-1];
    end
  end

  // Deserialiser state register.
  always_ff @(posedge clk32 or negedge reset_n) begin
    if (!reset_n) begin
      shreg        <= '0;
      bitcnt       <= '0;
      lrck_prev    <= 1'b0;
      primed       <= 1'b0;
      have_left    <= 1'b0;
      pending_left <= '0;
      gcnt         <= '0;
      tcnt         <= '0;
      left         <= '0;
      right        <= '0;
      locked       <= 1'b0;
      valid        <= 1'b0;
      err          <= 1'b0;
    end else begin
      shreg        <= shreg_n;
      bitcnt       <= bitcnt_n;
      lrck_prev    <= lrck_prev_n;
      primed       <= primed_n;
      have_left    <= have_left_n;
      pending_left <= pending_n;
      gcnt         <= gcnt_n;
      tcnt         <= tcnt_n;
      left         <= left_n;
      right        <= right_n;
      locked       <= locked_n;
      valid        <= valid_n;
      err          <= err_n;
    end
  end

  // The first sample after reset only captures lrck, so a word cut by reset is never counted.
  always_comb begin
    shreg_n     = shreg;
    bitcnt_n    = bitcnt;
    lrck_prev_n = lrck_prev;
    primed_n    = primed;
    have_left_n = have_left;
    pending_n   = pending_left;
    gcnt_n      = gcnt;
    tcnt_n      = tcnt;
    left_n      = left;
    right_n     = right;
    locked_n    = locked;
    valid_n     = 1'b0;
    err_n       = 1'b0;
    if (sample_q) begin
      tcnt_n = '0;
      if (!primed) begin
        primed_n    = 1'b1;
        lrck_prev_n = lrck_q;
      end else if (lrck_q == lrck_prev) begin
        if (bitcnt != 5'd0) begin
          if (bitcnt < 5'd16) shreg_n = {shreg[14:0], din_q};
          if (bitcnt != 5'd31) bitcnt_n = bitcnt + 5'd1;
        end
      end else begin
        if (bitcnt >= 5'd16) begin
          if (!lrck_prev) begin
            pending_n   = shreg;
            have_left_n = 1'b1;
          end else if (have_left) begin
            left_n      = pending_left;
            right_n     = shreg;
            valid_n     = 1'b1;
            have_left_n = 1'b0;
            if (gcnt != GW'(LOCK_FRAMES)) gcnt_n = gcnt + GW'(1);
            if (gcnt_n == GW'(LOCK_FRAMES)) locked_n = 1'b1;
          end
        end else if (bitcnt != 5'd0) begin
          err_n       = 1'b1;
          have_left_n = 1'b0;
          gcnt_n      = '0;
          locked_n    = 1'b0;
        end
        shreg_n     = {15'b0, din_q};
        bitcnt_n    = 5'd1;
        lrck_prev_n = lrck_q;
      end
    end else if (tcnt != TW'(TIMEOUT)) begin
      tcnt_n = tcnt + TW'(1);
      if (tcnt_n == TW'(TIMEOUT)) begin
        err_n       = 1'b1;
        locked_n    = 1'b0;
        bitcnt_n    = '0;
        have_left_n = 1'b0;
        gcnt_n      = '0;
      end
    end
  end

endmodule

// File: tb/tb_i2s_rx.sv
// Bench for i2s_rx: drives slot-level I2S traffic and compares valid/err events
// and lock state against a slot-level reference model.
`timescale 1ns/1ps
module tb_i2s_rx;

  localparam int unsigned TIMEOUT     = 255;
  localparam int unsigned LOCK_FRAMES = 2;

  logic        clk32 = 1'b0;
  logic        reset_n, bclk, lrck, din;
  logic [15:0] left, right;
  logic        valid, locked, err;

  int checks   = 0;
  int failures = 0;
  int period   = 20;

  logic [32:0] exp_q[$];
  logic [32:0] obs_q[$];

  // Reference model state, one entry per slot of the stream.
  bit          m_prev_known, m_prev_ch, m_counted, m_cur_ch, m_have, m_locked;
  int          m_cur_n, m_gcnt;
  logic [15:0] m_cur_data, m_pend;

  always #16 clk32 = ~clk32;

  i2s_rx #(.SYNC_STAGES(2), .TIMEOUT(TIMEOUT), .LOCK_FRAMES(LOCK_FRAMES)) dut (
    .clk32(clk32), .reset_n(reset_n), .i2s_bclk(bclk), .i2s_lrck(lrck), .i2s_din(din),
    .left(left), .right(right), .valid(valid), .locked(locked), .err(err)
  );

  always @(negedge clk32) begin
    if (reset_n) begin
      if (valid && err)  obs_q.push_back(33'h1_FFFF_FFFF);
      else if (valid)    obs_q.push_back({1'b0, left, right});
      else if (err)      obs_q.push_back({1'b1, 32'h0});
    end
  end

  task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, expv);
    end
  endtask

  // A slot boundary closes the previous slot if that slot was counted.
  task automatic model_close();
    if (m_cur_n < 16) begin
      exp_q.push_back({1'b1, 32'h0});
      m_have = 0; m_gcnt = 0; m_locked = 0;
    end else if (!m_cur_ch) begin
      m_pend = m_cur_data; m_have = 1;
    end else if (m_have) begin
      exp_q.push_back({1'b0, m_pend, m_cur_data});
      m_have = 0;
      if (m_gcnt < LOCK_FRAMES) m_gcnt++;
      if (m_gcnt == LOCK_FRAMES) m_locked = 1;
    end
  endtask

  task automatic model_slot(input bit ch, input int n, input logic [15:0] data);
    if (m_counted && m_prev_known && ch != m_prev_ch) model_close();
    m_counted    = m_prev_known && (ch != m_prev_ch);
    m_prev_known = 1;
    m_prev_ch    = ch;
    m_cur_ch     = ch;
    m_cur_n      = n;
    m_cur_data   = data;
  endtask

  task automatic model_reset(input bit continuing_ch);
    exp_q.delete(); obs_q.delete();
    m_prev_known = 1; m_prev_ch = continuing_ch;
    m_counted = 0; m_have = 0; m_gcnt = 0; m_locked = 0;
  endtask

  task automatic model_timeout();
    exp_q.push_back({1'b1, 32'h0});
    m_counted = 0; m_have = 0; m_gcnt = 0; m_locked = 0;
  endtask

  task automatic send_bit(input bit ch, input bit b);
    bclk = 1'b1; lrck = ch; din = b;
    repeat (period / 2) @(negedge clk32);
    bclk = 1'b0;
    repeat (period / 2) @(negedge clk32);
  endtask

  task automatic send_slot(input bit ch, input int n, input logic [15:0] data);
    model_slot(ch, n, data);
    for (int i = 0; i < n; i++) send_bit(ch, (i < 16) ? data[15-i] : 1'($urandom));
  endtask

  task automatic check_events(input string tag);
    logic [32:0] e, o;
    @(posedge clk32); #1;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      chk({tag, "_evt"}, o, e);
    end
    chk({tag, "_nevt"}, 33'(obs_q.size()), 33'(exp_q.size()));
    exp_q.delete(); obs_q.delete();
    chk({tag, "_lock"}, {32'b0, locked}, {32'b0, m_locked});
    @(negedge clk32);
  endtask

  task automatic frame(input logic [15:0] l, input logic [15:0] r, input int nl, input int nr,
                       input string tag);
    send_slot(1'b0, nl, l);
    check_events(tag);
    send_slot(1'b1, nr, r);
  endtask

  initial begin
    int t_err;
    reset_n = 1'b0; bclk = 1'b0; lrck = 1'b0; din = 1'b0;
    m_prev_known = 0; m_prev_ch = 0; m_counted = 0; m_cur_ch = 0; m_have = 0;
    m_locked = 0; m_cur_n = 0; m_gcnt = 0; m_cur_data = '0; m_pend = '0;
    repeat (4) @(negedge clk32);
    chk("rst_left",   {17'b0, left},   33'd0);
    chk("rst_right",  {17'b0, right},  33'd0);
    chk("rst_valid",  {32'b0, valid},  33'd0);
    chk("rst_locked", {32'b0, locked}, 33'd0);
    chk("rst_err",    {32'b0, err},    33'd0);
    reset_n = 1'b1;

    // Nominal stream, then sign/extreme values.
    send_slot(1'b1, 16, 16'($urandom));
    frame(16'h1234, 16'hABCD, 16, 16, "nom1");
    frame(16'h8001, 16'h7FFE, 16, 16, "nom2");
    frame(16'h8000, 16'hFFFF, 16, 16, "nom3");
    frame(16'h0000, 16'h0000, 16, 16, "ext1");

    // Short left word, then re-lock with randomised bit-clock periods.
    send_slot(1'b0, 10, 16'($urandom));
    send_slot(1'b1, 16, 16'($urandom));
    check_events("short");
    for (int i = 0; i < 3; i++) begin
      period = 2 * int'($urandom_range(2, 12));
      frame(16'($urandom), 16'($urandom), 16, 16, "relock");
    end

    // Long slots, then random lengths and periods.
    period = 20;
    frame(16'h5A5A, 16'hA5A5, 24, 24, "long");
    for (int i = 0; i < 6; i++) begin
      frame(16'($urandom), 16'($urandom), int'($urandom_range(16, 24)),
            int'($urandom_range(16, 24)), "rand");
      period = 2 * int'($urandom_range(2, 12));
    end
    period = 20;
    frame(16'($urandom), 16'($urandom), 16, 16, "pre_to");

    // Bit clock stops for 300 cycles while locked.
    model_timeout();
    t_err = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk32);
      if (err && t_err < 0) t_err = i;
    end
    chk("to_latency", 33'(t_err >= 235 && t_err <= 260), 33'd1);
    check_events("timeout");
    for (int i = 0; i < 3; i++) frame(16'($urandom), 16'($urandom), 16, 16, "to_relock");

    // Asynchronous reset in the middle of a left word.
    model_slot(1'b0, 16, 16'hC3C3);
    for (int i = 0; i < 6; i++) send_bit(1'b0, 1'($urandom));
    reset_n = 1'b0;
    #2;
    chk("arst_left",   {17'b0, left},   33'd0);
    chk("arst_right",  {17'b0, right},  33'd0);
    chk("arst_valid",  {32'b0, valid},  33'd0);
    chk("arst_locked", {32'b0, locked}, 33'd0);
    model_reset(1'b0);
    repeat (3) @(negedge clk32);
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) send_bit(1'b0, 1'($urandom));
    send_slot(1'b1, 16, 16'($urandom));
    frame(16'h1357, 16'h2468, 16, 16, "arst1");
    frame(16'($urandom), 16'($urandom), 16, 16, "arst2");
    frame(16'($urandom), 16'($urandom), 16, 16, "arst3");
    send_slot(1'b0, 16, 16'($urandom));
    check_events("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
